segre_lsu: RTL and testbench

- Parametrised load/store unit replacing the fixed-latency memory stage, between EX and WB.
- Issues requests to the data cache with a valid/ready handshake and stalls EX until the response arrives.
- Extracts and sign/zero-extends the addressed byte/half/word at any line offset.
- Builds byte enables and positioned write data for stores, and flags misaligned accesses instead of issuing them.

---
 rtl/segre_pkg.sv | 21 ++
 rtl/segre_lsu_align.sv | 79 +++++++
 rtl/segre_lsu.sv | 183 ++++++++++++++++++
 tb/tb_segre_lsu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core pipeline stages.
// The LSU uses the memory access type, its own two-state FSM and the line offset width.
package segre_pkg;

    localparam int WORD_SIZE             = 32;
    localparam int REG_SIZE              = 5;
    localparam int CACHE_LINE_SIZE_BYTES = 16;
    localparam int LINE_OFF_W            = $clog2(CACHE_LINE_SIZE_BYTES);

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/segre_lsu_align.sv
// Combinational data alignment for the LSU: load extraction and extension,
// store byte-enable and write-data positioning within a line, and misalignment detection.
module segre_lsu_align #(
    parameter int WORD_SIZE  = 32,
    parameter int LINE_BYTES = 16,
    localparam int OFF_W     = $clog2(LINE_BYTES)
) (
    input  logic [OFF_W-1:0]               offset,
    input  segre_pkg::memop_data_type_e    memop_type,
    input  logic                           sign_ext,
    input  logic [WORD_SIZE-1:0]           st_data,
    input  logic [LINE_BYTES*8-1:0]        line_rdata,
    output logic [WORD_SIZE-1:0]           ld_data,
    output logic [LINE_BYTES-1:0]          be,
    output logic [LINE_BYTES*8-1:0]        wdata,
    output logic                           misaligned
);
    import segre_pkg::*;

    logic [7:0]             ld_bytes [4];
    logic [OFF_W-1:0]       idx;
    logic [LINE_BYTES-1:0]  be_base;
    logic [LINE_BYTES*8-1:0] st_line;

    // Byte index wraps inside the line; wrapped bytes are only picked for
    // sizes that a misaligned check has already rejected.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx         = offset + OFF_W'(i);
            ld_bytes[i] = line_rdata[{idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        ld_data = '0;
        case (memop_type)
            BYTE: begin
                if (sign_ext && ld_bytes[0][7]) ld_data = '1;
                ld_data[7:0] = ld_bytes[0];
            end
            HALF: begin
                if (sign_ext && ld_bytes[1][7]) ld_data = '1;
                ld_data[15:0] = {ld_bytes[1], ld_bytes[0]};
            end
            default: ld_data[31:0] = {ld_bytes[3], ld_bytes[2], ld_bytes[1], ld_bytes[0]};
        endcase
    end

    always_comb begin
        be_base = '0;
        st_line = '0;
        case (memop_type)
            BYTE: begin
                be_base[0]    = 1'b1;
                st_line[7:0]  = st_data[7:0];
            end
            HALF: begin
                be_base[1:0]  = 2'b11;
                st_line[15:0] = st_data[15:0];
            end
            default: begin
                be_base[3:0]  = 4'hF;
                st_line[31:0] = st_data[31:0];
            end
        endcase
        be    = be_base << offset;
        wdata = st_line << {offset, 3'b000};
    end

    always_comb begin
        case (memop_type)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = offset[0];
            default: misaligned = |offset[1:0];
        endcase
    end

endmodule

// File: rtl/segre_lsu.sv
// Load/store unit between EX and WB: issues one data-cache request per aligned
// memory op with a valid/ready handshake and stalls EX until the response arrives.
module segre_lsu #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_SIZE   = 5,
    parameter int LINE_BYTES = 16
) (
    input  logic                        clk_i,
    input  logic                        rsn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WORD_SIZE-1:0]        alu_res_i,
    input  logic                        rf_we_i,
    input  logic [REG_SIZE-1:0]         rf_waddr_i,
    input  logic [WORD_SIZE-1:0]        rf_st_data_i,
    input  segre_pkg::memop_data_type_e memop_type_i,
    input  logic                        memop_sign_ext_i,
    input  logic                        memop_rd_i,
    input  logic                        memop_wr_i,
    input  logic                        tkbr_i,
    input  logic [WORD_SIZE-1:0]        new_pc_i,
    output logic                        dc_req_o,
    output logic                        dc_we_o,
    output logic [WORD_SIZE-1:0]        dc_addr_o,
    output logic [LINE_BYTES-1:0]       dc_be_o,
    output logic [LINE_BYTES*8-1:0]     dc_wdata_o,
    input  logic                        dc_ready_i,
    input  logic [LINE_BYTES*8-1:0]     dc_rdata_i,
    output logic                        valid_o,
    output logic [WORD_SIZE-1:0]        op_res_o,
    output logic                        rf_we_o,
    output logic [REG_SIZE-1:0]         rf_waddr_o,
    output logic                        tkbr_o,
    output logic [WORD_SIZE-1:0]        new_pc_o,
    output logic                        misaligned_o
);
    import segre_pkg::*;

    localparam int OFF_W = $clog2(LINE_BYTES);

    lsu_state_e state, state_next;

    logic [WORD_SIZE-1:0] addr_q;
    memop_data_type_e     type_q;
    logic                 sign_q;
    logic [WORD_SIZE-1:0] st_data_q;
    logic                 rd_q;
    logic                 wr_q;
    logic                 rf_we_q;
    logic [REG_SIZE-1:0]  waddr_q;
    logic                 tkbr_q;
    logic [WORD_SIZE-1:0] new_pc_q;

    logic                 memop;
    logic                 mis_flag;
    logic                 accept;
    logic                 pass;
    logic                 resp;

    logic [OFF_W-1:0]       al_offset;
    memop_data_type_e       al_type;
    logic [WORD_SIZE-1:0]   ld_data;
    logic [LINE_BYTES-1:0]  al_be;
    logic [LINE_BYTES*8-1:0] al_wdata;
    logic                   al_misaligned;

    // One aligner serves both states: IDLE needs the misalignment check on the
    // incoming op, WAIT needs extraction/positioning on the latched op.
    assign al_offset = (state == IDLE) ? alu_res_i[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign al_type   = (state == IDLE) ? memop_type_i : type_q;

    segre_lsu_align #(
        .WORD_SIZE  (WORD_SIZE),
        .LINE_BYTES (LINE_BYTES)
    ) u_align (
        .offset     (al_offset),
        .memop_type (al_type),
        .sign_ext   (sign_q),
        .st_data    (st_data_q),
        .line_rdata (dc_rdata_i),
        .ld_data    (ld_data),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_misaligned)
    );

    assign memop    = memop_rd_i | memop_wr_i;
    assign mis_flag = memop & al_misaligned;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pass       = 1'b0;
        resp       = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (memop && !al_misaligned) begin
                        accept     = 1'b1;
                        state_next = WAIT;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dc_ready_i) begin
                    resp       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready_o    = (state == IDLE);
    assign dc_req_o   = (state == WAIT);
    assign dc_we_o    = wr_q;
    assign dc_addr_o  = addr_q;
    assign dc_be_o    = (dc_req_o && wr_q) ? al_be    : '0;
    assign dc_wdata_o = (dc_req_o && wr_q) ? al_wdata : '0;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            addr_q       <= '0;
            type_q       <= BYTE;
            sign_q       <= 1'b0;
            st_data_q    <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rf_we_q      <= 1'b0;
            waddr_q      <= '0;
            tkbr_q       <= 1'b0;
            new_pc_q     <= '0;
            valid_o      <= 1'b0;
            op_res_o     <= '0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            tkbr_o       <= 1'b0;
            new_pc_o     <= '0;
            misaligned_o <= 1'b0;
        end else begin
            valid_o <= pass | resp;
            if (accept) begin
                addr_q    <= alu_res_i;
                type_q    <= memop_type_i;
                sign_q    <= memop_sign_ext_i;
                st_data_q <= rf_st_data_i;
                rd_q      <= memop_rd_i;
                wr_q      <= memop_wr_i;
                rf_we_q   <= rf_we_i;
                waddr_q   <= rf_waddr_i;
                tkbr_q    <= tkbr_i;
                new_pc_q  <= new_pc_i;
            end
            if (pass) begin
                op_res_o     <= alu_res_i;
                rf_we_o      <= rf_we_i & ~mis_flag;
                rf_waddr_o   <= rf_waddr_i;
                tkbr_o       <= tkbr_i;
                new_pc_o     <= new_pc_i;
                misaligned_o <= mis_flag;
            end
            if (resp) begin
                op_res_o     <= rd_q ? ld_data : addr_q;
                rf_we_o      <= rf_we_q;
                rf_waddr_o   <= waddr_q;
                tkbr_o       <= tkbr_q;
                new_pc_o     <= new_pc_q;
                misaligned_o <= 1'b0;
            end
        end
    end

    a_rd_wr_exclusive: assert property (@(posedge clk_i) disable iff (!rsn_i)
        valid_i |-> !(memop_rd_i && memop_wr_i));

endmodule

// File: tb/tb_segre_lsu.sv
// Directed bench for segre_lsu with a byte-level reference model and a responding cache.
module tb_segre_lsu;
    import segre_pkg::*;

    logic            clk_i = 1'b0;
    logic            rsn_i;
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     alu_res_i;
    logic            rf_we_i;
    logic [4:0]      rf_waddr_i;
    logic [31:0]     rf_st_data_i;
    memop_data_type_e memop_type_i;
    logic            memop_sign_ext_i;
    logic            memop_rd_i;
    logic            memop_wr_i;
    logic            tkbr_i;
    logic [31:0]     new_pc_i;
    logic            dc_req_o;
    logic            dc_we_o;
    logic [31:0]     dc_addr_o;
    logic [15:0]     dc_be_o;
    logic [127:0]    dc_wdata_o;
    logic            dc_ready_i;
    logic [127:0]    dc_rdata_i;
    logic            valid_o;
    logic [31:0]     op_res_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic            tkbr_o;
    logic [31:0]     new_pc_o;
    logic            misaligned_o;

    segre_lsu #(.WORD_SIZE(32), .REG_SIZE(5), .LINE_BYTES(16)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .valid_i(valid_i), .ready_o(ready_o),
        .alu_res_i(alu_res_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
        .rf_st_data_i(rf_st_data_i), .memop_type_i(memop_type_i),
        .memop_sign_ext_i(memop_sign_ext_i), .memop_rd_i(memop_rd_i),
        .memop_wr_i(memop_wr_i), .tkbr_i(tkbr_i), .new_pc_i(new_pc_i),
        .dc_req_o(dc_req_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
        .dc_be_o(dc_be_o), .dc_wdata_o(dc_wdata_o), .dc_ready_i(dc_ready_i),
        .dc_rdata_i(dc_rdata_i), .valid_o(valid_o), .op_res_o(op_res_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .tkbr_o(tkbr_o),
        .new_pc_o(new_pc_o), .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]  res;
        logic         we;
        logic [4:0]   waddr;
        logic         tkbr;
        logic [31:0]  pc;
        logic         mis;
        logic         req;
        logic [31:0]  addr;
        logic         st;
        logic [15:0]  be;
        logic [127:0] wdata;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic [7:0]  line [16];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          comp_cyc = 0;
    int          ready_low = 0;
    int          resp_delay = 0;
    int          wcnt = 0;
    bit          checking = 0;
    logic [31:0] last_res;
    logic        last_we, last_mis;
    logic [15:0] last_be;
    logic [127:0] last_wdata;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: treat the line as a byte array and assemble values arithmetically.
    function automatic exp_t model(input logic [31:0] addr, input memop_data_type_e t,
                                   input logic sext, input logic rd, input logic wr,
                                   input logic [31:0] sd, input logic we, input logic [4:0] wa,
                                   input logic tk, input logic [31:0] pc);
        exp_t   e;
        int     size, off;
        longint v;
        e = '{default: '0};
        size = (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
        off  = int'(addr % 16);
        e.res = addr; e.we = we; e.waddr = wa; e.tkbr = tk; e.pc = pc; e.addr = addr;
        if (rd || wr) begin
            if ((addr % size) != 0) begin
                e.mis = 1'b1;
                e.we  = 1'b0;
            end else begin
                e.req = 1'b1;
                e.st  = wr;
                if (wr)
                    for (int k = 0; k < size; k++) begin
                        e.be[off + k] = 1'b1;
                        e.wdata[(off + k) * 8 +: 8] = sd[k * 8 +: 8];
                    end
                if (rd) begin
                    v = 0;
                    for (int k = 0; k < size; k++) v += longint'(line[off + k]) << (8 * k);
                    if (sext && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                        v -= longint'(1) << (8 * size);
                    e.res = v[31:0];
                end
            end
        end
        return e;
    endfunction

    // Per-cycle compare against the model queue.
    always @(negedge clk_i) begin
        if (checking && rsn_i) begin
            if (!ready_o) ready_low++;
            if (dc_req_o) begin
                chk("dc_req_allowed", {127'b0, dc_req_o}, {127'b0, cur.req});
                chk("dc_addr", dc_addr_o, cur.addr);
            end
            if (valid_o) begin
                if (expq.size() == 0) begin
                    chk("valid_spurious", {127'b0, valid_o}, 128'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("op_res", op_res_o, e.res);
                    chk("rf_we", {127'b0, rf_we_o}, {127'b0, e.we});
                    chk("rf_waddr", rf_waddr_o, e.waddr);
                    chk("tkbr", {127'b0, tkbr_o}, {127'b0, e.tkbr});
                    chk("new_pc", new_pc_o, e.pc);
                    chk("misaligned", {127'b0, misaligned_o}, {127'b0, e.mis});
                    last_res = op_res_o;
                    last_we  = rf_we_o;
                    last_mis = misaligned_o;
                    comp_cyc = cyc;
                    done_cnt++;
                end
            end
        end
    end

    // Cache model: responds resp_delay cycles after dc_req_o rises.
    initial begin
        dc_ready_i = 1'b0;
        dc_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (dc_ready_i) begin
                dc_ready_i = 1'b0;
                wcnt = 0;
            end else if (dc_req_o && rsn_i) begin
                if (wcnt >= resp_delay) begin
                    for (int k = 0; k < 16; k++) dc_rdata_i[k * 8 +: 8] = line[k];
                    dc_ready_i = 1'b1;
                    chk("dc_we", {127'b0, dc_we_o}, {127'b0, cur.st});
                    chk("dc_be", dc_be_o, cur.be);
                    chk("dc_wdata", dc_wdata_o, cur.wdata);
                    last_be    = dc_be_o;
                    last_wdata = dc_wdata_o;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic drive(input logic [31:0] addr, input memop_data_type_e t, input logic sext,
                         input logic rd, input logic wr, input logic [31:0] sd,
                         input logic we, input logic [4:0] wa, input logic tk, input logic [31:0] pc);
        cur = model(addr, t, sext, rd, wr, sd, we, wa, tk, pc);
        expq.push_back(cur);
        valid_i = 1'b1; alu_res_i = addr; memop_type_i = t; memop_sign_ext_i = sext;
        memop_rd_i = rd; memop_wr_i = wr; rf_st_data_i = sd; rf_we_i = we;
        rf_waddr_i = wa; tkbr_i = tk; new_pc_i = pc;
    endtask

    task automatic do_op(input logic [31:0] addr, input memop_data_type_e t, input logic sext,
                         input logic rd, input logic wr, input logic [31:0] sd,
                         input logic we, input logic [4:0] wa, input logic tk, input logic [31:0] pc,
                         input int delay, input logic [31:0] lit, input int lat, input int rlow);
        int n, old, acc;
        n = 0;
        while (!ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
        resp_delay = delay;
        ready_low  = 0;
        old        = done_cnt;
        drive(addr, t, sext, rd, wr, sd, we, wa, tk, pc);
        acc = cyc;
        @(posedge clk_i); #1;
        valid_i = 1'b0; memop_rd_i = 1'b0; memop_wr_i = 1'b0;
        n = 0;
        while (done_cnt == old && n < 50) begin @(posedge clk_i); n++; end
        #1;
        if (done_cnt == old) begin
            chk("completion_timeout", 128'd0, 128'd1);
        end else begin
            chk("latency", comp_cyc - acc, lat);
            chk("ready_low_cycles", ready_low, rlow);
            chk("op_res_literal", last_res, lit);
        end
    endtask

    task automatic fill_line();
        for (int k = 0; k < 16; k++) line[k] = 8'(k * 17 + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsn_i = 1'b1; valid_i = 1'b0; alu_res_i = '0; rf_we_i = 1'b0; rf_waddr_i = '0;
        rf_st_data_i = '0; memop_type_i = BYTE; memop_sign_ext_i = 1'b0; memop_rd_i = 1'b0;
        memop_wr_i = 1'b0; tkbr_i = 1'b0; new_pc_i = '0;
        cur = '{default: '0};
        fill_line();
        #3 rsn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_valid", {127'b0, valid_o}, 128'd0);
        chk("reset_ready", {127'b0, ready_o}, 128'd1);
        chk("reset_req", {127'b0, dc_req_o}, 128'd0);
        chk("reset_op_res", op_res_o, 128'd0);
        chk("reset_misaligned", {127'b0, misaligned_o}, 128'd0);
        chk("reset_dc_addr", dc_addr_o, 128'd0);
        rsn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ready_after_release", {127'b0, ready_o}, 128'd1);
        checking = 1;

        // ALU pass-through ops
        do_op(32'h0000_1234, WORD, 0, 0, 0, 32'h0, 1, 5'd5, 0, 32'h0, 0, 32'h0000_1234, 1, 0);
        do_op(32'hABCD_0000, WORD, 0, 0, 0, 32'h0, 0, 5'd0, 1, 32'h8000_0040, 0, 32'hABCD_0000, 1, 0);
        // LB signed, response three cycles after request rises
        fill_line(); line[7] = 8'h80;
        do_op(32'h0000_1007, BYTE, 1, 1, 0, 32'h0, 1, 5'd7, 0, 32'h0, 3, 32'hFFFF_FF80, 5, 4);
        // LHU / LH at the last half of the line
        fill_line(); line[14] = 8'h34; line[15] = 8'hB2;
        do_op(32'h0000_200E, HALF, 0, 1, 0, 32'h0, 1, 5'd9, 0, 32'h0, 1, 32'h0000_B234, 3, 2);
        do_op(32'h0000_200E, HALF, 1, 1, 0, 32'h0, 1, 5'd9, 0, 32'h0, 0, 32'hFFFF_B234, 2, 1);
        // SW, response in the same cycle as the request
        do_op(32'h0000_3008, WORD, 0, 0, 1, 32'hDEAD_BEEF, 0, 5'd0, 0, 32'h0, 0, 32'h0000_3008, 2, 1);
        chk("sw_be_literal", last_be, 128'h0F00);
        chk("sw_wdata_literal", last_wdata, 128'h00000000_DEADBEEF_00000000_00000000);
        // Misaligned LW: no request, flagged, write enable suppressed
        do_op(32'h0000_4002, WORD, 0, 1, 0, 32'h0, 1, 5'd3, 0, 32'h0, 0, 32'h0000_4002, 1, 0);
        chk("lw_mis_literal", {127'b0, last_mis}, 128'd1);
        chk("lw_mis_we_literal", {127'b0, last_we}, 128'd0);
        // SB at the odd last offset is never flagged
        do_op(32'h0000_300F, BYTE, 0, 0, 1, 32'h1234_56A5, 0, 5'd0, 0, 32'h0, 2, 32'h0000_300F, 4, 3);
        chk("sb_be_literal", last_be, 128'h8000);
        chk("sb_wdata_literal", last_wdata, 128'hA5000000_00000000_00000000_00000000);
        do_op(32'h0000_3006, HALF, 0, 0, 1, 32'h0000_CAFE, 0, 5'd0, 0, 32'h0, 0, 32'h0000_3006, 2, 1);
        chk("sh_be_literal", last_be, 128'h00C0);
        // LBU zero-extends, LH misaligned, LW never extends
        fill_line(); line[15] = 8'hF0;
        do_op(32'h0000_100F, BYTE, 0, 1, 0, 32'h0, 1, 5'd11, 0, 32'h0, 0, 32'h0000_00F0, 2, 1);
        do_op(32'h0000_2001, HALF, 1, 1, 0, 32'h0, 1, 5'd12, 0, 32'h0, 0, 32'h0000_2001, 1, 0);
        fill_line(); line[0] = 8'h78; line[1] = 8'h56; line[2] = 8'h34; line[3] = 8'h87;
        do_op(32'h0000_6000, WORD, 1, 1, 0, 32'h0, 1, 5'd13, 0, 32'h0, 1, 32'h8734_5678, 3, 2);

        // Reset while waiting on the cache abandons the op
        resp_delay = 20;
        drive(32'h0000_5000, WORD, 0, 1, 0, 32'h0, 1, 5'd14, 0, 32'h0);
        @(posedge clk_i); #1;
        valid_i = 1'b0; memop_rd_i = 1'b0;
        @(posedge clk_i); #2;
        chk("req_before_reset", {127'b0, dc_req_o}, 128'd1);
        rsn_i = 1'b0;
        #1;
        chk("req_drop_on_reset", {127'b0, dc_req_o}, 128'd0);
        chk("valid_drop_on_reset", {127'b0, valid_o}, 128'd0);
        expq.delete();
        cur.req = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rsn_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_midwait_reset", {127'b0, ready_o}, 128'd1);
        chk("req_idle_after_reset", {127'b0, dc_req_o}, 128'd0);
        @(posedge clk_i); #1;
        fill_line(); line[4] = 8'h44; line[5] = 8'h33; line[6] = 8'h22; line[7] = 8'h11;
        do_op(32'h0000_5004, WORD, 0, 1, 0, 32'h0, 1, 5'd15, 0, 32'h0, 1, 32'h1122_3344, 3, 2);

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_drained", expq.size(), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
